// File: rtl/fetch_unit_prefetch.sv
// Instruction fetch front end: IMEM request/response port,
// prefetch buffer, bounded in-flight requests and redirect flush.
module fetch_unit_prefetch #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [ILEN-1:0]          imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [ILEN-1:0]          if_instr,
  output logic [XLEN-1:0]          if_pc,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = CW + OW;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   pf_rd_q, pf_rd_d;
  logic [PW-1:0]   pf_wr_q, pf_wr_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [ILEN-1:0] last_instr_q, last_instr_d;

  logic [XLEN-1:0] buf_pc_q    [DEPTH];
  logic [ILEN-1:0] buf_instr_q [DEPTH];
  logic [XLEN-1:0] pend_pc_q   [MAX_OUTSTANDING];

  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  logic            not_empty;
  logic [SW-1:0]   reserved;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;

  function automatic logic [PW-1:0] pf_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(MAX_OUTSTANDING - 1)) ?
           '0 : p + PW'(1);
  endfunction

  // Handshake decode and request gating
  always_comb begin
    not_empty  = (count_q != '0);
    head_pc    = buf_pc_q[rd_ptr_q];
    head_instr = buf_instr_q[rd_ptr_q];
    rsp_pc     = pend_pc_q[pf_rd_q];
    // slots already promised to kept in-flight responses
    reserved   = SW'(count_q) + SW'(outstanding_q)
               - SW'(discard_q);
    imem_req_valid = !rst && !redirect_valid &&
                     (outstanding_q < OW'(MAX_OUTSTANDING)) &&
                     (reserved < SW'(DEPTH));
    imem_req_addr  = rst ? RESET_PC : fetch_pc_q;
    req_fire = imem_req_valid && imem_req_ready;
    // a response with nothing in flight is ignored
    rsp_fire = imem_rsp_valid && (outstanding_q != '0);
    push = rsp_fire && (discard_q == '0) &&
           !redirect_valid && (count_q != CW'(DEPTH));
    pop  = not_empty && if_ready && !redirect_valid;
  end

  // Next-state computation
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    pf_rd_d       = pf_rd_q;
    pf_wr_d       = pf_wr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    last_pc_d     = last_pc_q;
    last_instr_d  = last_instr_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      pf_wr_d    = pf_inc(pf_wr_q);
    end
    if (rsp_fire) begin
      pf_rd_d = pf_inc(pf_rd_q);
    end
    outstanding_d = outstanding_q + OW'(req_fire)
                  - OW'(rsp_fire);

    if (not_empty) begin
      last_pc_d    = head_pc;
      last_instr_d = head_instr;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      // everything still in flight after this cycle is stale
      discard_d  = outstanding_q - OW'(rsp_fire);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (rsp_fire && (discard_q != '0))
        discard_d = discard_q - OW'(1);
    end
  end

  // Output drive; head value held while empty
  always_comb begin
    if_valid  = not_empty;
    if_pc     = not_empty ? head_pc : last_pc_q;
    if_instr  = not_empty ? head_instr : last_instr_q;
    buf_count = count_q;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      pf_rd_q       <= '0;
      pf_wr_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      last_pc_q     <= '0;
      last_instr_q  <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      pf_rd_q       <= pf_rd_d;
      pf_wr_q       <= pf_wr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      last_pc_q     <= last_pc_d;
      last_instr_q  <= last_instr_d;
    end
  end

  // Buffer and pending-PC storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= rsp_pc;
      buf_instr_q[wr_ptr_q] <= imem_rsp_data;
    end
    if (req_fire) begin
      pend_pc_q[pf_wr_q] <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit_prefetch.sv
// Bench for fetch_unit_prefetch: IMEM model, PC-stream
// scoreboard, directed scenarios then a random soak.
module tb_fetch_unit_prefetch;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;
  localparam logic [63:0] RPC = 64'h1000;

  logic            clk;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [63:0]     imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [63:0]     redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [63:0]     if_pc;
  logic [2:0]      buf_count;

  fetch_unit_prefetch #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .buf_count(buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // expected architectural PC stream
  logic [63:0] exp_q[$];
  logic [63:0] exp_next;

  // IMEM model state
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  int          ready_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  int          cyc = 0;
  int          last_due = 0;

  function automatic logic [31:0] instr_of(
    input logic [63:0] a
  );
    return a[31:0] ^ 32'hC0DE_0000 ^ {a[9:2], 24'h0};
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 64'd4;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    topup();
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    exp_q.delete();
    exp_next = pc & ~64'd3;
    topup();
  endtask

  // IMEM response / ready driver
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      imem_req_ready =
        (int'($urandom_range(0, 99)) < ready_pct);
      if (!rst && mq_addr.size() > 0 &&
          mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = instr_of(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: scoreboard, bounds, IMEM request capture
  initial begin
    logic [63:0] e;
    int d;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
        last_due = 0;
      end else begin
        tests++;
        if (buf_count > DEPTH ||
            mq_addr.size() + int'(imem_rsp_valid) > MAXO)
        begin
          fails++;
          $display("FAIL bounds: count %0d inflight %0d",
                   buf_count,
                   mq_addr.size() + int'(imem_rsp_valid));
        end
        if (imem_rsp_valid)
          check("rsp_outstanding",
                64'(dut.outstanding_q != 0), 64'd1);
        if (if_valid && if_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: got pc %h", if_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", if_pc, e);
            check("sb_instr", 64'(if_instr),
                  64'(instr_of(e)));
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          d = cyc + int'($urandom_range(lat_min, lat_max));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          mq_addr.push_back(imem_req_addr);
          mq_due.push_back(d);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  // Stimulus
  initial begin
    int found;
    int exp_disc;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b0;
    exp_next = RPC;
    repeat (3) next_cycle();

    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_count", 64'(buf_count), 64'd0);
    check("rst_addr", imem_req_addr, RPC);
    next_cycle();
    rst = 1'b0;
    if_ready = 1'b1;
    exp_q.delete();
    exp_next = RPC;
    topup();

    // sequential stream, one instr per cycle after fill
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("t1_req_valid", 64'(imem_req_valid), 64'd1);
        check("t1_req_addr", imem_req_addr, RPC);
        check("t1_count0", 64'(buf_count), 64'd0);
      end
      if (k >= 2) begin
        check("t1_no_gap", 64'(if_valid), 64'd1);
        check("t1_pc", if_pc, RPC + 64'(4 * (k - 2)));
      end
      next_cycle();
    end

    // decode stall fills buffer
    if_ready = 1'b0;
    repeat (19) next_cycle();
    @(negedge clk);
    check("t2_count_full", 64'(buf_count), 64'd4);
    check("t2_req_stall", 64'(imem_req_valid), 64'd0);
    check("t2_inflight",
          64'(mq_addr.size() + int'(imem_rsp_valid)), 64'd0);
    next_cycle();
    if_ready = 1'b1;
    repeat (10) next_cycle();

    // two in flight then redirect
    lat_min = 3;
    lat_max = 3;
    ready_pct = 0;
    repeat (8) next_cycle();
    ready_pct = 100;
    do_redirect(64'h2000);
    next_cycle();
    @(negedge clk);
    check("t3_req0_valid", 64'(imem_req_valid), 64'd1);
    check("t3_req0_addr", imem_req_addr, 64'h2000);
    next_cycle();
    @(negedge clk);
    check("t3_req1_addr", imem_req_addr, 64'h2004);
    next_cycle();
    do_redirect(64'h3002);
    @(negedge clk);
    check("t3_withdraw", 64'(imem_req_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t3_discard2", 64'(dut.discard_q), 64'd2);
    check("t3_rsp_a", 64'(imem_rsp_valid), 64'd1);
    check("t3_addr", imem_req_addr, 64'h3000);
    next_cycle();
    @(negedge clk);
    check("t3_discard1", 64'(dut.discard_q), 64'd1);
    check("t3_req_valid", 64'(imem_req_valid), 64'd1);
    check("t3_addr2", imem_req_addr, 64'h3000);
    check("t3_count_a", 64'(buf_count), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t3_discard0", 64'(dut.discard_q), 64'd0);
    check("t3_count_b", 64'(buf_count), 64'd0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      @(negedge clk);
      if (if_valid) begin
        found = 1;
        break;
      end
    end
    check("t3_first_seen", 64'(found), 64'd1);
    check("t3_first_pc", if_pc, 64'h3000);

    // redirect colliding with a response and a pop
    lat_min = 1;
    lat_max = 4;
    found = 0;
    exp_disc = 0;
    for (int i = 0; i < 500; i++) begin
      next_cycle();
      #2;
      if (imem_rsp_valid && if_valid &&
          mq_addr.size() > 0) begin
        if_ready = 1'b1;
        exp_disc = mq_addr.size();
        do_redirect(64'h4000);
        found = 1;
        break;
      end
      if_ready = (int'($urandom_range(0, 9)) < 6);
    end
    check("t4_found", 64'(found), 64'd1);
    next_cycle();
    @(negedge clk);
    check("t4_count_flush", 64'(buf_count), 64'd0);
    check("t4_discard", 64'(dut.discard_q),
          64'(exp_disc));
    if_ready = 1'b1;

    // IMEM not ready: address held, redirect withdraws
    ready_pct = 0;
    repeat (8) next_cycle();
    do_redirect(64'h5000);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 64'(imem_req_valid), 64'd1);
      check("t5_hold_addr", imem_req_addr, 64'h5000);
      next_cycle();
    end
    do_redirect(64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);
    check("t5_withdraw", 64'(imem_req_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t5_new_valid", 64'(imem_req_valid), 64'd1);
    check("t5_new_addr", imem_req_addr,
          64'hFFFF_FFFF_FFFF_FFF8);
    next_cycle();
    ready_pct = 100;
    repeat (20) next_cycle();

    // random soak against the PC-stream model
    ready_pct = 70;
    for (int i = 0; i < 10000; i++) begin
      next_cycle();
      if_ready = (int'($urandom_range(0, 9)) < 7);
      if ($urandom_range(0, 99) < 3)
        do_redirect({32'($urandom), 32'($urandom)});
    end
    next_cycle();
    if_ready = 1'b1;
    ready_pct = 100;
    repeat (30) next_cycle();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
